// File: rtl/ultrasound_sweep_if.sv
// ultrasound_sweep_if
//   Bundles the sweep sequencer's control, ranger handshake and result
//   signals. The master modport is the sequencer itself. The slave
//   modport is its environment: the guidance logic that starts sweeps and
//   reads results, plus the HC-SR04 ranging FSM.
//   start           start a sweep (sampled only when idle)
//   sensor_mask     bit i enables sensor slot i
//   ranger_done     done level from the ranging FSM
//   ranger_distance distance in inches, valid when ranger_done rises
//   ranger_enable   one-cycle enable pulse to the ranging FSM
//   curr_sensor     sensor index driven to the ranging FSM
//   best_distance   smallest distance of the current or last sweep
//   best_sensor     index of best_distance, 4'hF if none
//   sensor_timeout  sticky per-sensor watchdog flags for the current sweep
//   busy            sweep in progress
//   scan_done       one-cycle pulse at sweep end
//   state           FSM state for debug
interface ultrasound_sweep_if;
  logic       start;
  logic [5:0] sensor_mask;
  logic       ranger_done;
  logic [7:0] ranger_distance;
  logic       ranger_enable;
  logic [3:0] curr_sensor;
  logic [7:0] best_distance;
  logic [3:0] best_sensor;
  logic [5:0] sensor_timeout;
  logic       busy;
  logic       scan_done;
  logic [2:0] state;

  modport master (
    input  start, sensor_mask, ranger_done, ranger_distance,
    output ranger_enable, curr_sensor, best_distance, best_sensor,
           sensor_timeout, busy, scan_done, state
  );

  modport slave (
    output start, sensor_mask, ranger_done, ranger_distance,
    input  ranger_enable, curr_sensor, best_distance, best_sensor,
           sensor_timeout, busy, scan_done, state
  );
endinterface

// File: rtl/ultrasound_sweep.sv
// ultrasound_sweep
//   Sequencer in front of the HC-SR04 ranging FSM. A start pulse walks the
//   enabled sensors in index order. For each sensor it selects the sensor,
//   pulses the ranger enable and waits for the rising edge of ranger_done.
//   It keeps the smallest distance, and the lower index wins ties. A
//   watchdog bounds each measurement, and a settle gap follows each sensor
//   so that echoes die out.
// Ports
//   clock  system clock (27 MHz)
//   reset  synchronous, active-high
//   bus    ultrasound_sweep_if.master (signal list in the interface file)
module ultrasound_sweep #(
  parameter int         NUM_SENSORS    = 6,
  parameter int         SETTLE_CYCLES  = 1350000,
  parameter int         TIMEOUT_CYCLES = 29000000,
  parameter logic [7:0] NOTHING        = 8'hFF
) (
  input  logic               clock,
  input  logic               reset,
  ultrasound_sweep_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_SETTLE    = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [24:0] timer_q, timer_d;
  logic        done_q;
  logic        enable_q, enable_d;
  logic [3:0]  curr_q, curr_d;
  logic [7:0]  best_dist_q, best_dist_d;
  logic [3:0]  best_sens_q, best_sens_d;
  logic [5:0]  timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic        scan_done_q, scan_done_d;
  logic        done_evt;

  // Only a fresh rising edge counts, so a done level left over from the
  // previous sensor is never taken as this sensor's result.
  assign done_evt = bus.ranger_done & ~done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= 4'd0;
      timer_q     <= 25'd0;
      done_q      <= 1'b0;
      enable_q    <= 1'b0;
      curr_q      <= 4'd0;
      best_dist_q <= NOTHING;
      best_sens_q <= 4'hF;
      timeout_q   <= 6'd0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      timer_q     <= timer_d;
      done_q      <= bus.ranger_done;
      enable_q    <= enable_d;
      curr_q      <= curr_d;
      best_dist_q <= best_dist_d;
      best_sens_q <= best_sens_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    timer_d     = timer_q;
    enable_d    = 1'b0;
    curr_d      = curr_q;
    best_dist_d = best_dist_q;
    best_sens_d = best_sens_q;
    timeout_d   = timeout_q;
    busy_d      = busy_q;
    scan_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          index_d     = 4'd0;
          best_dist_d = NOTHING;
          best_sens_d = 4'hF;
          timeout_d   = 6'd0;
          busy_d      = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (index_q == 4'(NUM_SENSORS)) begin
          // scan_done is raised on the edge into FINISH. The pulse then
          // lands one cycle after CHECK sees the end of the list.
          scan_done_d = 1'b1;
          state_d     = S_FINISH;
        end else if (!bus.sensor_mask[index_q[2:0]]) begin
          index_d = index_q + 4'd1;
        end else begin
          curr_d   = index_q;
          enable_d = 1'b1;
          timer_d  = 25'd0;
          state_d  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // The done event is tested first, so it wins over a watchdog
        // expiry in the same cycle.
        if (done_evt) begin
          if (bus.ranger_distance < best_dist_q) begin
            best_dist_d = bus.ranger_distance;
            best_sens_d = index_q;
          end
          timer_d = 25'd0;
          state_d = S_SETTLE;
        end else if (timer_q == 25'(TIMEOUT_CYCLES - 1)) begin
          timeout_d[index_q[2:0]] = 1'b1;
          timer_d = 25'd0;
          state_d = S_SETTLE;
        end else begin
          timer_d = timer_q + 25'd1;
        end
      end
      S_SETTLE: begin
        if (timer_q == 25'(SETTLE_CYCLES - 1)) begin
          timer_d = 25'd0;
          index_d = index_q + 4'd1;
          state_d = S_CHECK;
        end else begin
          timer_d = timer_q + 25'd1;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ranger_enable  = enable_q;
  assign bus.curr_sensor    = curr_q;
  assign bus.best_distance  = best_dist_q;
  assign bus.best_sensor    = best_sens_q;
  assign bus.sensor_timeout = timeout_q;
  assign bus.busy           = busy_q;
  assign bus.scan_done      = scan_done_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_ultrasound_sweep.sv
module tb_ultrasound_sweep;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  ultrasound_sweep_if bus ();

  ultrasound_sweep #(
    .NUM_SENSORS   (6),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(100),
    .NOTHING       (8'hFF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Ranger model: after an enable it drops done, waits a few cycles and
  // raises done with the table distance, unless the sensor is silent.
  // In manual mode the bench drives done/distance directly.
  logic [7:0] dist_tab [6];
  logic [5:0] silent;
  logic       manual, m_done;
  logic [7:0] m_dist;
  logic       r_done, r_busy;
  logic [2:0] r_cnt;
  logic [7:0] r_dist;
  logic [3:0] r_sens;

  always @(posedge clock) begin
    if (reset) begin
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= 3'd0;
      r_dist <= 8'd0;
      r_sens <= 4'd0;
    end else if (bus.ranger_enable) begin
      r_done <= 1'b0;
      r_busy <= 1'b1;
      r_cnt  <= 3'd3;
      r_dist <= dist_tab[bus.curr_sensor[2:0]];
      r_sens <= bus.curr_sensor;
    end else if (r_busy) begin
      if (r_cnt == 3'd0) begin
        r_busy <= 1'b0;
        if (!silent[r_sens[2:0]]) r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  assign bus.ranger_done     = manual ? m_done : r_done;
  assign bus.ranger_distance = manual ? m_dist : r_dist;

  // Passive monitor: enable pulses, their sensor index, over-long pulses,
  // scan_done pulses and cycles spent waiting on sensor 3.
  int         en_cnt, en_long, scan_cnt, w3;
  logic       en_prev;
  logic [3:0] en_sens [64];

  initial begin
    en_cnt = 0; en_long = 0; scan_cnt = 0; w3 = 0; en_prev = 1'b0;
  end

  always @(negedge clock) begin
    if (bus.ranger_enable) begin
      if (en_prev) en_long <= en_long + 1;
      else begin
        en_sens[en_cnt % 64] <= bus.curr_sensor;
        en_cnt <= en_cnt + 1;
      end
    end
    en_prev <= bus.ranger_enable;
    if (bus.scan_done) scan_cnt <= scan_cnt + 1;
    if (bus.state == 3'd2 && bus.curr_sensor == 4'd3) w3 <= w3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_scan(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (bus.scan_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input logic [3:0] cs, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (bus.state == s && bus.curr_sensor == cs) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "global timeout");
  end

  int en_base, long_base, sc_base, w3_base;
  bit ok;

  initial begin
    errors = 0; checks = 0;
    bus.start = 1'b0; bus.sensor_mask = 6'd0;
    manual = 1'b0; m_done = 1'b0; m_dist = 8'd0; silent = 6'd0;
    dist_tab[0] = 8'd40; dist_tab[1] = 8'd25; dist_tab[2] = 8'd60;
    dist_tab[3] = 8'd25; dist_tab[4] = 8'd90; dist_tab[5] = 8'd200;
    reset = 1'b1;
    tick(3);
    check("rst_state",   32'(bus.state), 0);
    check("rst_enable",  32'(bus.ranger_enable), 0);
    check("rst_curr",    32'(bus.curr_sensor), 0);
    check("rst_best",    32'(bus.best_distance), 32'hFF);
    check("rst_bsens",   32'(bus.best_sensor), 32'hF);
    check("rst_timeout", 32'(bus.sensor_timeout), 0);
    check("rst_busy",    32'(bus.busy), 0);
    check("rst_scan",    32'(bus.scan_done), 0);
    reset = 1'b0;
    tick(2);

    // Full sweep, tie at 25 keeps sensor 1
    bus.sensor_mask = 6'h3F;
    en_base = en_cnt; long_base = en_long; sc_base = scan_cnt;
    pulse_start();
    check("t1_state_check", 32'(bus.state), 1);
    check("t1_busy",        32'(bus.busy), 1);
    tick(1);
    check("t1_enable_hi",   32'(bus.ranger_enable), 1);
    check("t1_curr0",       32'(bus.curr_sensor), 0);
    tick(1);
    check("t1_enable_lo",   32'(bus.ranger_enable), 0);
    check("t1_state_wait",  32'(bus.state), 2);
    wait_scan(2000, ok);
    check("t1_scan_seen", 32'(ok), 1);
    check("t1_best",      32'(bus.best_distance), 25);
    check("t1_bsens",     32'(bus.best_sensor), 1);
    check("t1_timeout",   32'(bus.sensor_timeout), 0);
    tick(3);
    check("t1_en_count",  32'(en_cnt - en_base), 6);
    check("t1_en_long",   32'(en_long - long_base), 0);
    check("t1_scan_count", 32'(scan_cnt - sc_base), 1);
    check("t1_busy_end",  32'(bus.busy), 0);
    for (int k = 0; k < 6; k++) check("t1_en_sensor", 32'(en_sens[(en_base + k) % 64]), 32'(k));

    // Sensors 2 and 4 only
    bus.sensor_mask = 6'b010100;
    dist_tab[2] = 8'd30; dist_tab[4] = 8'd12;
    en_base = en_cnt;
    pulse_start();
    wait_scan(2000, ok);
    check("t2_scan_seen", 32'(ok), 1);
    check("t2_best",      32'(bus.best_distance), 12);
    check("t2_bsens",     32'(bus.best_sensor), 4);
    check("t2_timeout",   32'(bus.sensor_timeout), 0);
    tick(2);
    check("t2_en_count",  32'(en_cnt - en_base), 2);
    check("t2_en_s0",     32'(en_sens[en_base % 64]), 2);
    check("t2_en_s1",     32'(en_sens[(en_base + 1) % 64]), 4);

    // Sensor 3 silent, watchdog fires
    for (int k = 0; k < 6; k++) dist_tab[k] = 8'd50;
    silent = 6'b001000;
    bus.sensor_mask = 6'h3F;
    en_base = en_cnt; w3_base = w3;
    pulse_start();
    wait_scan(3000, ok);
    check("t3_scan_seen", 32'(ok), 1);
    check("t3_timeout",   32'(bus.sensor_timeout), 32'b001000);
    check("t3_best",      32'(bus.best_distance), 50);
    check("t3_bsens",     32'(bus.best_sensor), 0);
    tick(2);
    check("t3_wait_len",  32'(w3 - w3_base), 100);
    check("t3_en_count",  32'(en_cnt - en_base), 6);
    silent = 6'd0;

    // Empty mask: scan_done exactly 8 cycles after start
    bus.sensor_mask = 6'd0;
    en_base = en_cnt;
    pulse_start();
    tick(6);
    check("t4_scan_early", 32'(bus.scan_done), 0);
    tick(1);
    check("t4_scan_hi",    32'(bus.scan_done), 1);
    check("t4_best",       32'(bus.best_distance), 32'hFF);
    check("t4_bsens",      32'(bus.best_sensor), 32'hF);
    tick(1);
    check("t4_scan_lo",    32'(bus.scan_done), 0);
    check("t4_busy",       32'(bus.busy), 0);
    check("t4_en_count",   32'(en_cnt - en_base), 0);

    // Second start ignored, then reset during WAIT_DONE
    dist_tab[0] = 8'd40; dist_tab[1] = 8'd25;
    bus.sensor_mask = 6'h3F;
    pulse_start();
    wait_state(3'd3, 4'd0, 200, ok);
    check("t5_reach_settle", 32'(ok), 1);
    check("t5_best_s0",      32'(bus.best_distance), 40);
    pulse_start();
    check("t5_restart_best", 32'(bus.best_distance), 40);
    check("t5_restart_busy", 32'(bus.busy), 1);
    wait_state(3'd2, 4'd1, 200, ok);
    check("t5_reach_wait1",  32'(ok), 1);
    reset = 1'b1;
    tick(1);
    check("t5_rst_state",   32'(bus.state), 0);
    check("t5_rst_enable",  32'(bus.ranger_enable), 0);
    check("t5_rst_curr",    32'(bus.curr_sensor), 0);
    check("t5_rst_best",    32'(bus.best_distance), 32'hFF);
    check("t5_rst_bsens",   32'(bus.best_sensor), 32'hF);
    check("t5_rst_timeout", 32'(bus.sensor_timeout), 0);
    check("t5_rst_busy",    32'(bus.busy), 0);
    check("t5_rst_scan",    32'(bus.scan_done), 0);
    reset = 1'b0;
    sc_base = scan_cnt;
    tick(40);
    check("t5_no_scan",     32'(scan_cnt - sc_base), 0);
    check("t5_idle",        32'(bus.state), 0);

    // Done held high at enable is not an event; then done and watchdog coincide
    manual = 1'b1; m_done = 1'b1; m_dist = 8'd7;
    bus.sensor_mask = 6'b000001;
    pulse_start();
    wait_state(3'd2, 4'd0, 10, ok);
    check("t6_reach_wait", 32'(ok), 1);
    tick(10);
    check("t6_stale_done", 32'(bus.state), 2);
    tick(40);
    m_done = 1'b0;
    tick(49);
    m_done = 1'b1;
    tick(1);
    check("t6_state_settle", 32'(bus.state), 3);
    check("t6_best",         32'(bus.best_distance), 7);
    check("t6_bsens",        32'(bus.best_sensor), 0);
    check("t6_timeout",      32'(bus.sensor_timeout), 0);
    wait_scan(200, ok);
    check("t6_scan_seen",    32'(ok), 1);
    check("t6_best_end",     32'(bus.best_distance), 7);
    check("t6_timeout_end",  32'(bus.sensor_timeout), 0);
    manual = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ultrasound_sweep.md
# ultrasound_sweep

Sequencer sitting directly upstream of the HC-SR04 ranging FSM. On a start pulse it walks the enabled ultrasound sensors in index order. For each sensor it selects the sensor, pulses the ranger's enable and waits for its done. It then keeps the smallest distance, with the lower index winning ties. At the end it reports the closest sensor and distance to the guidance logic. A watchdog guards against a ranger that never completes, and a settle gap between sensors lets echoes die out.

## Interface
- NUM_SENSORS, 6: number of sensor slots scanned, indices 0..NUM_SENSORS-1; maximum 6.
- SETTLE_CYCLES, 1350000: idle gap after each measurement (50 ms at 27 MHz).
- TIMEOUT_CYCLES, 29000000: watchdog per measurement. Must exceed the ranger's worst case of echo timeout plus 1 s power cycle.
- NOTHING, 8'hFF: initial and "no target" distance value.
- clock  input  1  system clock, 27 MHz.
- reset  input  1  synchronous, active-high.
- start  input  1  begin a sweep; sampled only in IDLE.
- sensor_mask  input  6  bit i = 1 means sensor i is scanned.
- ranger_done  input  1  done level from the ranging FSM.
- ranger_distance  input  8  distance in inches from the ranging FSM; valid when ranger_done rises.
- ranger_enable  output  1  one-cycle enable pulse to the ranging FSM.
- curr_sensor  output  4  sensor index driven to the ranging FSM.
- best_distance  output  8  smallest distance of the current or last sweep.
- best_sensor  output  4  index of best_distance; 4'hF if none.
- sensor_timeout  output  6  sticky per-sensor watchdog flags for the current sweep.
- busy  output  1  high from start acceptance until FINISH.
- scan_done  output  1  one-cycle pulse at sweep end.
- state  output  3  FSM state, exposed for debug.

## Operation
- States: IDLE=0, CHECK=1, WAIT_DONE=2, SETTLE=3, FINISH=4. Encodings 5..7 recover to IDLE.
- Reset values:
  - State and outputs: state IDLE, ranger_enable 0, curr_sensor 0, best_distance NOTHING, best_sensor 4'hF, sensor_timeout 0, busy 0, scan_done 0.
  - Internal: index 0, timer 0, done_q 0.
- done_q registers ranger_done every cycle, in all states. The measurement-complete event is ranger_done & ~done_q.
- IDLE:
  - scan_done <= 0.
  - On start: index <= 0, best_distance <= NOTHING, best_sensor <= 4'hF, sensor_timeout <= 0, busy <= 1, go to CHECK.
- CHECK:
  - If index == NUM_SENSORS: go to FINISH.
  - Else if sensor_mask[index] == 0: index <= index+1 and stay in CHECK (one cycle per skipped slot).
  - Else: curr_sensor <= index, ranger_enable <= 1, timer <= 0, go to WAIT_DONE.
- WAIT_DONE:
  - ranger_enable <= 0 on entry, so the pulse is exactly 1 cycle.
  - On the done event: if ranger_distance < best_distance (strict), best_distance <= ranger_distance and best_sensor <= index. Then timer <= 0 and go to SETTLE.
  - Else if timer == TIMEOUT_CYCLES-1: sensor_timeout[index] <= 1, timer <= 0, go to SETTLE. No distance update.
  - Else: timer <= timer+1.
- SETTLE:
  - When timer == SETTLE_CYCLES-1: timer <= 0, index <= index+1, go to CHECK.
  - Else: timer <= timer+1.
- FINISH: scan_done <= 1, busy <= 0, go to IDLE.
- curr_sensor holds its value from CHECK selection through SETTLE and after the sweep. The ranger reads it combinationally.
- Arithmetic: timer is 25 bits. index is 4 bits. The comparison is an unsigned 8-bit comparison.

## Timing
- start at cycle t in IDLE, with sensor 0 enabled:
  - t+1: state CHECK, busy high.
  - t+2: curr_sensor valid, ranger_enable high.
  - t+3: ranger_enable low, state WAIT_DONE.
- A done event at cycle d is sampled at d. best_distance updates at d+1, and SETTLE starts at d+1.
- scan_done is high for exactly 1 cycle, one cycle after CHECK sees index == NUM_SENSORS. best_distance, best_sensor and sensor_timeout are stable from then until the next accepted start.
- start while busy is ignored.
- A done event outside WAIT_DONE is ignored.
- ranger_done already high at enable does not count as the event; the FSM waits for the ranger to drop done and raise it again.
- Simultaneous done event and watchdog expiry: the done event wins and the distance is used.
- All-zero sensor_mask: the sweep completes with NOTHING/4'hF and scan_done 2+NUM_SENSORS cycles after start.
- Reset mid-sweep: everything returns to reset values on the next edge. ranger_enable drops, and no scan_done is produced.

## Test plan
Simulation parameters: TIMEOUT_CYCLES=100, SETTLE_CYCLES=4.
- mask 6'h3F, ranger model returns 40,25,60,25,90,200 -> best_distance 25, best_sensor 1 (tie keeps lowest index), sensor_timeout 0, one scan_done pulse, six 1-cycle ranger_enable pulses with curr_sensor 0..5.
- mask 6'b010100 (sensors 2 and 4), returns 30 and 12 -> only curr_sensor 2 and 4 enabled, best 12 at sensor 4.
- Sensor 3 never raises done, others return 50 -> sensor_timeout 6'b001000, WAIT_DONE lasts 100 cycles for sensor 3, best 50 at sensor 0.
- mask 0, start -> scan_done 8 cycles after start, best 8'hFF/4'hF, no ranger_enable.
- Second start pulse mid-sweep, then reset asserted during WAIT_DONE -> second start ignored, then all outputs at reset values one cycle after reset, no scan_done.
- Watchdog expiry and done rising edge in the same cycle with distance 7 -> best 7 recorded, timeout flag clear.
